alu_seq: RTL
============

# alu_seq

Parametrised sequential ALU for the teaching CPU datapath, replacing the fixed 8-bit, 3-bit-opcode ALU. It keeps the eight legacy opcodes, adds subtract/OR/shift/rotate/compare and an iterative multiply, and produces registered status flags. Start/busy/done handshaking lets the controller stall on multi-cycle operations. It sits between the accumulator/data bus and the accumulator write-back path.

## Interface
- `WIDTH`, default 8: operand and result width (≥4).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_enable`  in  1  start strobe; accepted only when `busy`=0.
- `op_code`  in  4  operation, sampled on accept.
- `data`  in  WIDTH  bus operand, sampled on accept.
- `accum`  in  WIDTH  accumulator operand, sampled on accept.
- `alu_out`  out  WIDTH  registered result.
- `zero`, `carry`, `neg`, `ovf`  out  1 each  registered flags.
- `acc_zero`  out  1  combinational `accum`==0, used by SKZ.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse, result/flags updated this cycle.

## Operation
- Opcodes: 0 HLT, 1 SKZ, 6 STA, 7 JMP → pass `accum`; 2 ADD `accum+data`; 3 AND; 4 XOR; 5 LDA pass `data`; 8 SUB `accum-data`; 9 OR; A SHL `accum<<1`; B SHR logical `accum>>1`; C ROL; D ROR; E MUL; F CMP.
- Legacy 3-bit codes zero-extended behave exactly as before.
- Flags update only on `done`, otherwise hold.
- `zero` = result==0; `neg` = result MSB.
- `carry`: ADD carry-out; SUB/CMP borrow (1 iff `accum`<`data` unsigned); SHL/ROL shifted-out MSB; SHR/ROR shifted-out LSB; MUL 1 iff upper WIDTH bits of 2·WIDTH product nonzero; else 0.
- `ovf`: signed two's-complement overflow for ADD/SUB/CMP; 0 otherwise.
- CMP: flags from `accum-data`; `alu_out` holds its previous value.
- MUL: unsigned shift-add, one multiplier bit per cycle, LSB first; `alu_out` = low WIDTH bits.
- State machine: IDLE → (accept, op≠E) IDLE with `done`; IDLE → (accept, op=E) MUL; MUL counts WIDTH iterations, then back to IDLE with `done`.
- `alu_enable` while `busy` is ignored; operands are not resampled.
- Reset in any state: state IDLE, iteration count 0, `alu_out`=0, `zero`=`carry`=`neg`=`ovf`=0, `busy`=0, `done`=0. `acc_zero` follows `accum`.

## Timing
- Single-cycle ops: accept on edge k; `alu_out`, flags and `done`=1 valid after edge k. Throughput is one op per cycle (back-to-back accepts allowed).
- MUL: accept on edge k. `busy`=1 after k, and iterations occur on edges k+1 … k+WIDTH. Result, flags and `done` appear after edge k+WIDTH, with `busy`=0 in the same cycle. A new accept is legal on edge k+WIDTH+1 (`alu_enable` sampled while `busy`=0).
- `done` lasts exactly one cycle unless the next accept is also single-cycle.
- `acc_zero` has no register delay.

## Structure
- Package `alu_pkg`: opcode localparams (`OP_HLT` … `OP_CMP`), state enum `{ST_IDLE, ST_MUL}`, flag index constants.
- Sub-module `alu_mul_iter` (WIDTH param): load/step/count/done interface and 2·WIDTH product register. The top level holds the op decode, flag logic and FSM.

## Test plan
- WIDTH=8, ADD 0xFF+0x01 → `alu_out`=0x00, `zero`=1, `carry`=1, `ovf`=0, `done` one cycle after accept.
- SUB 0x80−0x01 → 0x7F, `ovf`=1, `carry`=0. CMP 0x05 vs 0x09 → `carry`=1, `neg`=1, `alu_out` unchanged.
- SHL 0x81 → 0x02 with `carry`=1. ROR 0x01 → 0x80 with `carry`=1. Legacy LDA (op 5) `data`=0x3C → 0x3C.
- MUL 0x0F×0x11 → 0xFF, `carry`=0, `busy` for 8 cycles, `done` after edge k+8. MUL 0x10×0x10 → 0x00, `carry`=1, `zero`=1.
- `alu_enable` pulsed with ADD during MUL busy → ignored, MUL result intact. `rst` asserted mid-MUL → all outputs 0 immediately, next ADD works normally.
- WIDTH=16 regression: ADD 0xFFFF+1 → 0, `carry`=1; MUL 0x0100×0x0100 → 0, `carry`=1, latency 16.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state type and flag layout for alu_seq.
// Imported by alu_seq and alu_mul_iter.
package alu_pkg;

    // Legacy 3-bit opcodes keep their values, zero-extended to 4 bits
    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_SKZ = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_LDA = 4'h5;
    localparam logic [3:0] OP_STA = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_SUB = 4'h8;
    localparam logic [3:0] OP_OR  = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_ROL = 4'hC;
    localparam logic [3:0] OP_ROR = 4'hD;
    localparam logic [3:0] OP_MUL = 4'hE;
    localparam logic [3:0] OP_CMP = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_NEG   = 2;
    localparam int FLG_OVF   = 3;
    localparam int FLG_W     = 4;

    function automatic logic [FLG_W-1:0] mk_flags(
        input logic z,
        input logic c,
        input logic n,
        input logic v
    );
        logic [FLG_W-1:0] f;
        f            = '0;
        f[FLG_ZERO]  = z;
        f[FLG_CARRY] = c;
        f[FLG_NEG]   = n;
        f[FLG_OVF]   = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one multiplier bit per step,
// LSB first. Ports: clk, rst (async high), load (capture operands),
// step (one iteration), mcand/mplier operands, prod_next (product after
// the current step), done (this step is the last of WIDTH).
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] prod_next,
    output logic               done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH:0]     sum;

    // Upper half accumulates; lower half holds the unconsumed multiplier
    // bits and shifts right as product bits settle into it.
    always_comb begin
        sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
            + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_next = {sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        count_d = count_q;
        done    = 1'b0;
        if (load) begin
            prod_d  = {{WIDTH{1'b0}}, mplier};
            mcand_d = mcand;
            count_d = '0;
        end else if (step) begin
            prod_d  = prod_next;
            count_d = count_q + CW'(1);
            done    = (count_q == CW'(WIDTH - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            mcand_q <= '0;
            count_q <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered result/flags and start/busy/done.
// Ports: clk, rst (async high), alu_enable, op_code, data, accum in;
// alu_out, zero, carry, neg, ovf, acc_zero, busy, done out.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_enable,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] accum,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry,
    output logic             neg,
    output logic             ovf,
    output logic             acc_zero,
    output logic             busy,
    output logic             done
);

    localparam int MSB = WIDTH - 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic [FLG_W-1:0]   flags_q, flags_d;
    logic               done_q, done_d;

    logic               mul_load;
    logic               mul_step;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_v;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .load      (mul_load),
        .step      (mul_step),
        .mcand     (accum),
        .mplier    (data),
        .prod_next (mul_prod),
        .done      (mul_done)
    );

    // Single-cycle datapath
    always_comb begin
        add_w = {1'b0, accum} + {1'b0, data};
        sub_w = {1'b0, accum} - {1'b0, data};
        res   = accum;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op_code)
            OP_ADD: begin
                res   = add_w[MSB:0];
                res_c = add_w[WIDTH];
                res_v = (accum[MSB] == data[MSB])
                     && (add_w[MSB] != accum[MSB]);
            end
            OP_SUB, OP_CMP: begin
                // Bit WIDTH of the extended difference is the borrow
                res   = sub_w[MSB:0];
                res_c = sub_w[WIDTH];
                res_v = (accum[MSB] != data[MSB])
                     && (sub_w[MSB] != accum[MSB]);
            end
            OP_AND: res = accum & data;
            OP_XOR: res = accum ^ data;
            OP_OR:  res = accum | data;
            OP_LDA: res = data;
            OP_SHL: begin
                res   = {accum[MSB-1:0], 1'b0};
                res_c = accum[MSB];
            end
            OP_SHR: begin
                res   = {1'b0, accum[MSB:1]};
                res_c = accum[0];
            end
            OP_ROL: begin
                res   = {accum[MSB-1:0], accum[MSB]};
                res_c = accum[MSB];
            end
            OP_ROR: begin
                res   = {accum[0], accum[MSB:1]};
                res_c = accum[0];
            end
            default: res = accum;
        endcase
    end

    // FSM next state and result/flag capture
    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (alu_enable) begin
                    if (op_code == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = ST_MUL;
                    end else begin
                        // CMP only sets flags
                        if (op_code != OP_CMP) begin
                            alu_out_d = res;
                        end
                        flags_d = mk_flags(res == '0, res_c,
                                           res[MSB], res_v);
                        done_d  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_done) begin
                    alu_out_d = mul_prod[MSB:0];
                    flags_d   = mk_flags(
                        mul_prod[MSB:0] == '0,
                        |mul_prod[2*WIDTH-1:WIDTH],
                        mul_prod[MSB],
                        1'b0);
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            alu_out_q <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
        end
    end

    assign alu_out  = alu_out_q;
    assign zero     = flags_q[FLG_ZERO];
    assign carry    = flags_q[FLG_CARRY];
    assign neg      = flags_q[FLG_NEG];
    assign ovf      = flags_q[FLG_OVF];
    assign busy     = (state_q == ST_MUL);
    assign done     = done_q;
    assign acc_zero = (accum == '0);

endmodule
